// File: rtl/debounced_pio_in.sv
// Memory-mapped input port: per-bit two-flop synchroniser, debounce counter,
// programmable edge capture with write-1-to-clear and a maskable level interrupt.
module debounced_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RAW  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAP  = 3'd3;
    localparam logic [2:0] ADDR_RISE = 3'd4;
    localparam logic [2:0] ADDR_FALL = 3'd5;

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [CW-1:0]    cnt_r [WIDTH];
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_cap_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [31:0]      readdata_r;

    logic [WIDTH-1:0] upd_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clear_s;
    logic             wr_s;
    logic [31:0]      rd_mux_s;
    logic             unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata;

    // Two-flop synchroniser for the raw asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= IDLE_VEC;
            sync2_r <= IDLE_VEC;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: a new level is accepted only after an unbroken run of differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_r <= IDLE_VEC;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Event strobe: the cycle on which a bit's accepted level flips
    always_comb begin
        upd_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
        end
    end

    assign set_s = (upd_s & sync2_r & rise_en_r) | (upd_s & ~sync2_r & fall_en_r);

    // Write-1-to-clear mask for the capture register
    always_comb begin
        if (wr_s && (address == ADDR_CAP)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = '0;
        end
    end

    // Control registers and sticky capture; a same-cycle set beats the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_r <= '0;
            edge_cap_r <= '0;
            rise_en_r  <= {WIDTH{1'b1}};
            fall_en_r  <= '0;
        end else begin
            edge_cap_r <= set_s | (edge_cap_r & ~clear_s);
            if (wr_s) begin
                case (address)
                    ADDR_MASK: irq_mask_r <= writedata[WIDTH-1:0];
                    ADDR_RISE: rise_en_r  <= writedata[WIDTH-1:0];
                    ADDR_FALL: fall_en_r  <= writedata[WIDTH-1:0];
                    default:   irq_mask_r <= irq_mask_r;
                endcase
            end
        end
    end

    // Read multiplexer, zero-extended to the bus width
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_DATA: rd_mux_s[WIDTH-1:0] = stable_r;
            ADDR_RAW:  rd_mux_s[WIDTH-1:0] = sync2_r;
            ADDR_MASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
            ADDR_CAP:  rd_mux_s[WIDTH-1:0] = edge_cap_r;
            ADDR_RISE: rd_mux_s[WIDTH-1:0] = rise_en_r;
            ADDR_FALL: rd_mux_s[WIDTH-1:0] = fall_en_r;
            default:   rd_mux_s = 32'd0;
        endcase
    end

    // Read data registered every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = |(edge_cap_r & irq_mask_r);

endmodule

// File: doc/debounced_pio_in.md
# debounced_pio_in

Parametrised, memory-mapped input port for push-buttons and switches: WIDTH inputs are synchronised, individually debounced, and edge-detected. Each bit is programmable for rising, falling or both edges, and a sticky capture register drives a maskable interrupt. It sits on the processor's Avalon-MM slave fabric, with one slave per bank of buttons/switches.

## Interface
- WIDTH, 4: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required to accept a new level, >=1. Counter width is clog2(DEBOUNCE_CYCLES+1).
- IDLE_LEVEL, 1: reset value of every debounced bit. Default 1 suits active-low buttons.

- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low; clock clk.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; only bits [WIDTH-1:0] are used.
- in_port  in  WIDTH  raw asynchronous pins.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  interrupt, level.

## Operation
- Register map (address):
  - 0 DATA: debounced level, RO.
  - 1 RAW: synchroniser output, RO.
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
  - 4 RISE_EN: RW.
  - 5 FALL_EN: RW.
  - 6, 7: read 0, writes ignored.
  - Writes to 0 and 1 are ignored.
- Reset values:
  - sync stages, stable, and per-bit counters: IDLE_LEVEL, IDLE_LEVEL, 0.
  - IRQ_MASK, EDGE_CAPTURE, FALL_EN: 0.
  - RISE_EN: all ones.
  - readdata 0, irq 0.
- Synchroniser: two flops per bit, sync = 2nd stage.
- Debounce, per bit i, every cycle:
  - if sync[i]==stable[i]: cnt[i] <= 0.
  - else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i] <= sync[i], cnt[i] <= 0, event asserted this cycle.
  - else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles clears the count and never reaches stable.
- Event direction: rise = update to 1; fall = update to 0.
- set[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- EDGE_CAPTURE[i] <= set[i] ? 1 : (clear_wr & writedata[i]) ? 0 : keep.
  - Set wins over a same-cycle clear, so no event is lost.
  - Writing 0 bits leaves those bits unchanged.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.
- Changing RISE_EN/FALL_EN does not alter bits already captured.
- Clearing IRQ_MASK deasserts irq without clearing the capture.
- Reads have no side effects.

## Timing
- readdata is registered every cycle from address, without chipselect qualification. Read data is valid the cycle after the address is presented, giving a read latency of 1.
- Register writes take effect at the clk edge where chipselect & ~write_n.
- Pin-to-DATA latency: pin change before edge 0, sync updated at edge 2, stable updated at edge 2+DEBOUNCE_CYCLES. EDGE_CAPTURE is set on that same edge, and irq is asserted after it.
- DEBOUNCE_CYCLES=1: stable follows sync one edge later.
- A count restarts from 0 whenever sync returns to stable mid-count.
- Asynchronous reset mid-count returns every register to its reset value immediately. The first release edge then behaves as cycle 0 with no spurious event, because stable and sync both start at IDLE_LEVEL.
- Bits are fully independent. Simultaneous events on several bits all set in the same cycle.

## Test plan
- Reset, WIDTH=4, DEBOUNCE_CYCLES=4, in_port=4'hF held:
  - read addr 0 -> 0xF; addr 4 -> 0xF; addrs 2, 3, 5 -> 0; irq=0.
- Press, in_port[0] 1->0 held:
  - DATA bit0 falls exactly 6 edges after the change.
  - With FALL_EN=1 and IRQ_MASK=1: EDGE_CAPTURE=0x1 and irq=1 on that edge.
  - Write 0x1 to addr 3 -> EDGE_CAPTURE=0, irq=0.
- Bounce, in_port[1] low for 3 cycles then high, repeated:
  - DATA stays 0xF; RAW shows the bounces; EDGE_CAPTURE stays 0.
  - Then held low for 4+ cycles: a single fall event.
- Both-edge mode, RISE_EN=FALL_EN=0x4:
  - press then release bit2 -> two captures; irq pulses twice, with a clear between them.
  - With RISE_EN=0: the release is not captured.
- Set/clear collision:
  - Write 0xF to addr 3 on the exact edge where bit3's event fires -> EDGE_CAPTURE[3]=1, other bits cleared.
- Reset asserted mid-count (cnt=2) -> DATA=0xF, no capture after release; address 6 reads 0.
